serial_adder: RTL and testbench

Bit-serial multi-bit adder built around one instance of the team's existing full_adder cell, plus a registered carry and operand/result shift registers. It accepts two WIDTH-bit operands and a carry-in on a start handshake. It produces one sum bit per clock, LSB first, and then presents the registered WIDTH-bit sum and carry-out with a one-cycle done pulse. It is the sequential consumer stage of the full_adder cell and trades area for WIDTH+1 cycles of latency.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 108 ++++++++++
 tb/tb_serial_adder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter only has to reach width-1.
  function automatic int cnt_bits(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder, a carry flop and shift registers,
// one sum bit per clock LSB first, then a one-cycle done with the registered result.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_bits(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_cout;
  logic             load, step, last;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // A start in the done cycle chains straight into the next operation.
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (step) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {fa_s, res_sh[WIDTH-1:1]};
      carry  <= fa_cout;
      if (!last) cnt <= cnt + 1'b1;
    end
  end

  // Result registers update only on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (last) begin
      sum  <= {fa_s, res_sh[WIDTH-1:1]};
      cout <= fa_cout;
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected {cout,sum},
// a negedge monitor pops and compares on every done.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [W:0] expq[$];
  logic [W:0] last_res;
  logic       have_last = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Monitor: compare on done, otherwise verify the result is held.
  always @(negedge clk) begin
    if (rst) begin
      have_last = 1'b0;
    end else if (done) begin
      done_cnt++;
      if (expq.size() == 0) begin
        chk("unexpected_done", {cout, sum}, '1);
      end else begin
        last_res = expq.pop_front();
        chk("result", {cout, sum}, last_res);
        have_last = 1'b1;
      end
    end else if (have_last) begin
      chk("hold", {cout, sum}, last_res);
    end
  end

  // Present an operation; the next posedge must accept it (IDLE or DONE).
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic [W:0] exp);
    a = ta; b = tb; cin = tc; start = 1'b1;
    expq.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int bcnt, d0, t0, t1;
    logic [W-1:0] ra, rb;
    logic         rc;

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // 5A+3C: latency and busy length
    start_op(8'h5A, 8'h3C, 1'b0, 9'h096);
    bcnt = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("busy_cycles", bcnt, 8);
    chk("done_seen", done, 1);
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    chk("idle_busy", busy, 0);

    // carry boundaries
    #1 start_op(8'hFF, 8'h01, 1'b0, 9'h100);
    wait_done("ff01");
    start_op(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    wait_done("ffff1");
    @(negedge clk); #1;

    // start while busy is ignored
    d0 = done_cnt;
    start_op(8'h10, 8'h20, 1'b0, 9'h030);
    @(posedge clk); @(posedge clk); #1;
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("ignore_one_done", done_cnt - d0, 1);
    chk("ignore_queue_empty", expq.size(), 0);

    // reset in the 4th shift cycle
    start_op(8'h11, 8'h22, 1'b0, 9'h033);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    expq.delete();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    @(posedge clk); #1 rst = 1'b0;
    d0 = done_cnt;
    repeat (15) @(posedge clk);
    #1 chk("abort_no_done", done_cnt - d0, 0);
    start_op(8'h01, 8'h02, 1'b0, 9'h003);
    wait_done("after_abort");
    @(negedge clk); #1;

    // start held high: new operands in each DONE cycle
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    expq.push_back(9'h010);
    t0 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_done("b2b");
      t1 = $time;
      if (k > 0) chk("b2b_period", (t1 - t0) / 10, 9);
      t0 = t1;
      #1;
      case (k)
        0: begin a = 8'h80; b = 8'h80; cin = 1'b1; expq.push_back(9'h101); end
        1: begin a = 8'hC3; b = 8'h3C; cin = 1'b1; expq.push_back(9'h100); end
        2: begin a = 8'h7F; b = 8'h00; cin = 1'b0; expq.push_back(9'h07F); end
        default: start = 1'b0;
      endcase
    end
    @(negedge clk); #1;

    // random operands with 0..3 cycle gaps
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      start_op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'b0, rc});
      wait_done("rand");
      #1;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if (!done) #1;
    end
    repeat (12) @(posedge clk);
    #1 chk("queue_drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
